// File: rtl/random_target_timer.sv
`default_nettype none
// ============================================================================
//  Module   : random_target_timer
//  Purpose  : Schedules reaction-game target events from an LFSR word. Each
//             event fires after a random delay, waits for a player ack and
//             is scored as a hit or a miss in saturating counters.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1   clock, all state changes on posedge
//    reset        in   1   asynchronous active-low reset
//    rnd          in  16   LFSR word, sampled only on the IDLE->WAIT edge
//    enable       in   1   run request
//    level        in   3   right-shift applied to the random delay field
//    ack          in   1   player response (already synchronised)
//    clear        in   1   synchronous clear of hits/misses (wins over incr)
//    fire         out  1   target active
//    busy         out  1   FSM not idle
//    false_start  out  1   one-cycle pulse: ack arrived while waiting
//    hits         out  8   saturating hit counter
//    misses       out  8   saturating miss counter
// ============================================================================
module random_target_timer #(
    parameter int DELAY_W   = 10,
    parameter int MIN_DELAY = 4,
    parameter int TIMEOUT   = 50,
    parameter int COOLDOWN  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] rnd,
    input  logic        enable,
    input  logic [2:0]  level,
    input  logic        ack,
    input  logic        clear,
    output logic        fire,
    output logic        busy,
    output logic        false_start,
    output logic [7:0]  hits,
    output logic [7:0]  misses
);

    localparam int D_W   = DELAY_W + 1;
    localparam int T_W   = $clog2(TIMEOUT + 1);
    localparam int C_W   = $clog2(COOLDOWN + 1);
    localparam int TC_W  = (T_W > C_W) ? T_W : C_W;
    // One counter is shared by the WAIT delay, FIRE timeout and COOL phases.
    localparam int CNT_W = (D_W > TC_W) ? D_W : TC_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_FIRE = 2'd2,
        S_COOL = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nx;
    logic               r_false_start;
    logic               w_false_start_nx;
    logic [7:0]         r_hits;
    logic [7:0]         r_misses;
    logic [7:0]         w_hits_nx;
    logic [7:0]         w_misses_nx;
    logic               w_hit;
    logic               w_miss;
    logic [D_W-1:0]     w_delay;

    // Upper LFSR bits are not part of the delay field.
    generate
        if (DELAY_W < 16) begin : g_rnd_unused
            logic w_unused_rnd;
            assign w_unused_rnd = ^rnd[15:DELAY_W];
        end
    endgenerate

    // Extra top bit keeps MIN_DELAY + max field from overflowing.
    assign w_delay = D_W'(MIN_DELAY) + ({1'b0, rnd[DELAY_W-1:0]} >> level);

    always_comb begin
        w_state_nx       = r_state;
        w_cnt_nx         = r_cnt;
        w_false_start_nx = 1'b0;
        w_hit            = 1'b0;
        w_miss           = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_cnt_nx   = CNT_W'(w_delay);
                    w_state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!enable) begin
                    w_cnt_nx   = '0;
                    w_state_nx = S_IDLE;
                end else if (ack) begin
                    w_false_start_nx = 1'b1;
                    w_miss           = 1'b1;
                    w_cnt_nx         = CNT_W'(COOLDOWN);
                    w_state_nx       = S_COOL;
                end else if (r_cnt == CNT_W'(1)) begin
                    // Timeout counter starts from zero on FIRE entry.
                    w_cnt_nx   = '0;
                    w_state_nx = S_FIRE;
                end else begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end
            end
            S_FIRE: begin
                // enable is deliberately ignored: a fired target is always scored.
                if (ack) begin
                    w_hit      = 1'b1;
                    w_cnt_nx   = CNT_W'(COOLDOWN);
                    w_state_nx = S_COOL;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_miss     = 1'b1;
                    w_cnt_nx   = CNT_W'(COOLDOWN);
                    w_state_nx = S_COOL;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            S_COOL: begin
                // Counts COOLDOWN cycles down to zero, then leaves on the next edge.
                if (!enable || (r_cnt == '0)) begin
                    w_cnt_nx   = '0;
                    w_state_nx = S_IDLE;
                end else begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_cnt_nx   = '0;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_hits_nx   = r_hits;
        w_misses_nx = r_misses;
        if (clear) begin
            w_hits_nx   = '0;
            w_misses_nx = '0;
        end else begin
            if (w_hit && (r_hits != 8'hFF)) begin
                w_hits_nx = r_hits + 8'd1;
            end
            if (w_miss && (r_misses != 8'hFF)) begin
                w_misses_nx = r_misses + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_false_start <= 1'b0;
            r_hits        <= '0;
            r_misses      <= '0;
        end else begin
            r_state       <= w_state_nx;
            r_cnt         <= w_cnt_nx;
            r_false_start <= w_false_start_nx;
            r_hits        <= w_hits_nx;
            r_misses      <= w_misses_nx;
        end
    end

    assign fire        = (r_state == S_FIRE);
    assign busy        = (r_state != S_IDLE);
    assign false_start = r_false_start;
    assign hits        = r_hits;
    assign misses      = r_misses;

endmodule
`default_nettype wire

// File: tb/tb_random_target_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_random_target_timer
//  Purpose  : Directed self-checking bench for random_target_timer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_random_target_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] rnd;
    logic        enable;
    logic [2:0]  level;
    logic        ack;
    logic        clear;
    logic        fire;
    logic        busy;
    logic        false_start;
    logic [7:0]  hits;
    logic [7:0]  misses;

    int n_pass  = 0;
    int n_total = 0;

    random_target_timer dut (
        .clk         (clk),
        .reset       (reset),
        .rnd         (rnd),
        .enable      (enable),
        .level       (level),
        .ack         (ack),
        .clear       (clear),
        .fire        (fire),
        .busy        (busy),
        .false_start (false_start),
        .hits        (hits),
        .misses      (misses)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Sampling edge T0: rnd is scrambled right after to show it is taken only once.
    task automatic start_event(input logic [15:0] r, input logic [2:0] l);
        rnd    = r;
        level  = l;
        enable = 1'b1;
        tick();
        rnd    = 16'hFFFF;
    endtask

    // Edges after T0 until fire is seen; -1 if the bound expires.
    task automatic wait_fire(input int max, output int n);
        n = 0;
        while (n < max) begin
            tick();
            n++;
            if (fire) return;
        end
        n = -1;
    endtask

    task automatic do_clear;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; rnd = '0; enable = 1'b0; level = '0; ack = 1'b0; clear = 1'b0;
        tick(); tick();
        if ({fire, busy, false_start, hits, misses} !== 19'd0) $display("FAIL reset_in got %h need 0", {fire, busy, false_start, hits, misses}); else n_pass++;
        n_total++;
        reset = 1'b1;
        tick();
        if ({fire, busy, false_start, hits, misses} !== 19'd0) $display("FAIL reset_out got %h need 0", {fire, busy, false_start, hits, misses}); else n_pass++;
        n_total++;
    endtask

    task automatic test_basic_hit;
        int n;
        start_event(16'h0000, 3'd0);
        wait_fire(20, n);
        if (n !== 4) $display("FAIL basic_rise got %0d need 4", n); else n_pass++;
        n_total++;
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        if ({fire, hits} !== {1'b0, 8'd1}) $display("FAIL basic_hit fire/hits got %b/%0d need 0/1", fire, hits); else n_pass++;
        n_total++;
        n = 0;
        while (busy && n < 40) begin tick(); n++; end
        enable = 1'b0;
        if (n !== 9) $display("FAIL basic_cool got %0d need 9", n); else n_pass++;
        n_total++;
        tick();
    endtask

    task automatic test_delay_range;
        int n;
        start_event(16'h03FF, 3'd0);
        wait_fire(2000, n);
        if (n !== 1027) $display("FAIL delay_l0 got %0d need 1027", n); else n_pass++;
        n_total++;
        ack = 1'b1; tick(); ack = 1'b0; enable = 1'b0; tick();
        start_event(16'h03FF, 3'd3);
        wait_fire(2000, n);
        if (n !== 131) $display("FAIL delay_l3 got %0d need 131", n); else n_pass++;
        n_total++;
        ack = 1'b1; tick(); ack = 1'b0; enable = 1'b0; tick();
        // Bits above the field are ignored: 0xFC05 -> field 5 >> 2 = 1 -> D = 5.
        start_event(16'hFC05, 3'd2);
        wait_fire(50, n);
        if (n !== 5) $display("FAIL delay_hi got %0d need 5", n); else n_pass++;
        n_total++;
        ack = 1'b1; tick(); ack = 1'b0; enable = 1'b0; tick();
    endtask

    task automatic test_timeout;
        int n;
        do_clear();
        start_event(16'h0000, 3'd0);
        wait_fire(20, n);
        n = 1;
        while (n < 200) begin
            tick();
            if (!fire) break;
            n++;
        end
        if (n !== 50) $display("FAIL timeout_len got %0d need 50", n); else n_pass++;
        n_total++;
        if ({hits, misses} !== {8'd0, 8'd1}) $display("FAIL timeout_score got %0d/%0d need 0/1", hits, misses); else n_pass++;
        n_total++;
        enable = 1'b0; tick();
        do_clear();
        start_event(16'h0000, 3'd0);
        wait_fire(20, n);
        repeat (49) tick();
        if (fire !== 1'b1) $display("FAIL last_cycle_fire got %b need 1", fire); else n_pass++;
        n_total++;
        ack = 1'b1; tick(); ack = 1'b0;
        if ({fire, hits, misses} !== {1'b0, 8'd1, 8'd0}) $display("FAIL last_cycle_ack got %b/%0d/%0d need 0/1/0", fire, hits, misses); else n_pass++;
        n_total++;
        enable = 1'b0; tick();
    endtask

    task automatic test_false_start;
        do_clear();
        start_event(16'h0000, 3'd0);
        tick();
        ack = 1'b1; tick(); ack = 1'b0;
        if ({false_start, fire, busy, misses, hits} !== {1'b1, 1'b0, 1'b1, 8'd1, 8'd0}) $display("FAIL fs_pulse got %b%b%b/%0d/%0d need 101/1/0", false_start, fire, busy, misses, hits); else n_pass++;
        n_total++;
        tick();
        if ({false_start, fire} !== 2'b00) $display("FAIL fs_width got %b%b need 00", false_start, fire); else n_pass++;
        n_total++;
        enable = 1'b0; tick();
        start_event(16'h0000, 3'd0);
        tick();
        enable = 1'b0;
        tick();
        repeat (6) tick();
        if ({busy, fire, hits, misses} !== {2'b00, 8'd0, 8'd1}) $display("FAIL wait_abort got %b%b/%0d/%0d need 00/0/1", busy, fire, hits, misses); else n_pass++;
        n_total++;
    endtask

    task automatic test_saturate_clear;
        int n;
        do_clear();
        for (int i = 0; i < 300; i++) begin
            start_event(16'h0000, 3'd0);
            wait_fire(20, n);
            ack = 1'b1; tick(); ack = 1'b0;
            enable = 1'b0; tick();
            if (i == 254) begin
                if (hits !== 8'd255) $display("FAIL sat_reach got %0d need 255", hits); else n_pass++;
                n_total++;
            end
        end
        if (hits !== 8'd255) $display("FAIL sat_hold got %0d need 255", hits); else n_pass++;
        n_total++;
        do_clear();
        for (int i = 0; i < 3; i++) begin
            start_event(16'h0000, 3'd0);
            wait_fire(20, n);
            ack = 1'b1; tick(); ack = 1'b0;
            enable = 1'b0; tick();
        end
        if (hits !== 8'd3) $display("FAIL hits_three got %0d need 3", hits); else n_pass++;
        n_total++;
        start_event(16'h0000, 3'd0);
        wait_fire(20, n);
        ack = 1'b1; clear = 1'b1; tick(); ack = 1'b0; clear = 1'b0;
        if ({hits, fire, busy} !== {8'd0, 1'b0, 1'b1}) $display("FAIL clear_wins got %0d/%b%b need 0/01", hits, fire, busy); else n_pass++;
        n_total++;
        enable = 1'b0; tick();
    endtask

    task automatic test_async_reset;
        int n;
        do_clear();
        start_event(16'h0000, 3'd0);
        wait_fire(20, n);
        ack = 1'b1; tick(); ack = 1'b0; enable = 1'b0; tick();
        start_event(16'h0000, 3'd0);
        wait_fire(20, n);
        #2 reset = 1'b0;
        #1;
        if ({fire, busy, hits, misses} !== 18'd0) $display("FAIL async_reset got %b%b/%0d/%0d need 00/0/0", fire, busy, hits, misses); else n_pass++;
        n_total++;
        enable = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        start_event(16'h0000, 3'd0);
        wait_fire(20, n);
        if (n !== 4) $display("FAIL restart_rise got %0d need 4", n); else n_pass++;
        n_total++;
        ack = 1'b1; tick(); ack = 1'b0; enable = 1'b0; tick();
        if (hits !== 8'd1) $display("FAIL restart_hit got %0d need 1", hits); else n_pass++;
        n_total++;
    endtask

    initial begin
        test_reset();
        test_basic_hit();
        test_delay_range();
        test_timeout();
        test_false_start();
        test_saturate_clear();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
